// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the MIPS-like IF/DEC/ALU/MEM datapath.
// Define ILLEGAL_TRAP_EN to make unknown opcodes a sticky halt; the default build retires them as a NOP.
module mc_control_fsm #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        PC_en,
  output logic        PC_sel,
  output logic        RFsel_wr,
  output logic        RFsel_B,
  output logic        RFwr_en,
  output logic        ALUsel_B,
  output logic        MEMwr_en,
  output logic [3:0]  func,
  output logic        instr_done
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR,
    S_WB_ALU, S_WB_MEM, S_BRANCH, S_ILLEGAL
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_AND = 4'b0010;
  localparam logic [3:0] F_OR  = 4'b0011;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [3:0] cnt_q, cnt_d;

  logic       is_alu, is_imm, is_load, is_store, is_branch;
  logic [3:0] alu_func;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^instr[25:4];

  always_comb begin
    is_alu    = 1'b0;
    is_imm    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    alu_func  = F_ADD;
    case (op_q)
      OP_RTYPE: begin is_alu = 1'b1; alu_func = instr[3:0]; end
      OP_LI,
      OP_ADDI:  begin is_alu = 1'b1; is_imm = 1'b1; end
      OP_ANDI:  begin is_alu = 1'b1; is_imm = 1'b1; alu_func = F_AND; end
      OP_ORI:   begin is_alu = 1'b1; is_imm = 1'b1; alu_func = F_OR; end
      OP_LB,
      OP_LW:    is_load = 1'b1;
      OP_SB,
      OP_SW:    is_store = 1'b1;
      OP_B,
      OP_BEQ,
      OP_BNE:   is_branch = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    PC_en      = 1'b0;
    PC_sel     = 1'b0;
    RFsel_wr   = 1'b0;
    RFsel_B    = 1'b0;
    RFwr_en    = 1'b0;
    ALUsel_B   = 1'b0;
    MEMwr_en   = 1'b0;
    func       = F_ADD;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        op_d    = instr[31:26];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_alu || is_load || is_store) state_d = S_EXEC;
        else if (is_branch)                state_d = S_BRANCH;
        else                               state_d = S_ILLEGAL;
      end
      S_EXEC: begin
        ALUsel_B = is_imm || is_load || is_store;
        RFsel_B  = is_store;
        func     = alu_func;
        if (is_load) begin
          cnt_d   = LAT_M1;
          state_d = S_MEM_RD;
        end else if (is_store) begin
          cnt_d   = LAT_M1;
          state_d = S_MEM_WR;
        end else begin
          state_d = S_WB_ALU;
        end
      end
      S_MEM_RD: begin
        ALUsel_B = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
        else             state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        // The counter still holds its load value only in the first cycle, so the write strobe fires once.
        ALUsel_B = 1'b1;
        RFsel_B  = 1'b1;
        MEMwr_en = (cnt_q == LAT_M1);
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          PC_en      = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_WB_ALU: begin
        RFwr_en    = 1'b1;
        PC_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_WB_MEM: begin
        RFwr_en    = 1'b1;
        RFsel_wr   = 1'b1;
        PC_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        func       = F_SUB;
        RFsel_B    = 1'b1;
        PC_en      = 1'b1;
        instr_done = 1'b1;
        if (op_q == OP_B)        PC_sel = 1'b1;
        else if (op_q == OP_BEQ) PC_sel = zero;
        else                     PC_sel = ~zero;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_ILLEGAL;
`else
        PC_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: three instances (MEM_LAT 1,2,3) share stimulus; expectations come
// from a per-cycle instruction-phase model, a hand-computed vector table and corner sequences.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic [11:0] obs [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // obs bits: PC_en, PC_sel, RFsel_wr, RFsel_B, RFwr_en, ALUsel_B, MEMwr_en, func[3:0], instr_done
  localparam int B_PCEN = 11, B_PCSEL = 10, B_RFSW = 9, B_RFSB = 8, B_RFWR = 7;
  localparam int B_ALUB = 6, B_MEMW = 5, B_DONE = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pc_en, pc_sel, rfsel_wr, rfsel_b, rfwr_en, alusel_b, memwr_en, done;
    logic [3:0] fn;
    mc_control_fsm #(.MEM_LAT(g + 1)) u_dut (
      .clk(clk), .reset(reset), .instr(instr), .zero(zero),
      .PC_en(pc_en), .PC_sel(pc_sel), .RFsel_wr(rfsel_wr), .RFsel_B(rfsel_b),
      .RFwr_en(rfwr_en), .ALUsel_B(alusel_b), .MEMwr_en(memwr_en),
      .func(fn), .instr_done(done)
    );
    assign obs[g] = {pc_en, pc_sel, rfsel_wr, rfsel_b, rfwr_en, alusel_b, memwr_en, fn, done};
  end

  localparam logic [31:0] I_ADD  = 32'h8000_0020;
  localparam logic [31:0] I_SUB  = 32'h8000_0021;
  localparam logic [31:0] I_OR   = 32'h8000_0023;
  localparam logic [31:0] I_LI   = {6'b111000, 26'h0000_123};
  localparam logic [31:0] I_ADDI = {6'b110000, 26'h1234_567};
  localparam logic [31:0] I_ANDI = {6'b110010, 26'h0000_0ff};
  localparam logic [31:0] I_ORI  = {6'b110011, 26'h0000_0f0};
  localparam logic [31:0] I_B    = {6'b111111, 26'h0000_010};
  localparam logic [31:0] I_BEQ  = {6'b000000, 26'h0000_010};
  localparam logic [31:0] I_BNE  = {6'b000001, 26'h0000_010};
  localparam logic [31:0] I_LB   = {6'b000011, 26'h0000_004};
  localparam logic [31:0] I_LW   = {6'b001111, 26'h0000_004};
  localparam logic [31:0] I_SB   = {6'b000111, 26'h0000_004};
  localparam logic [31:0] I_SW   = {6'b011111, 26'h0000_004};
  localparam logic [31:0] I_ILL  = {6'b101010, 26'h0000_000};
`ifdef ILLEGAL_TRAP_EN
  localparam logic [11:0] ILL_C3 = 12'h000;
`else
  localparam logic [11:0] ILL_C3 = 12'h801;
`endif

  typedef enum {K_ALU, K_LD, K_ST, K_BR, K_ILL} kind_e;

  // Expected outputs k cycles after reset release, for an instruction held on instr and repeated.
  function automatic logic [11:0] model(logic [31:0] ins, logic z, int lat, int k);
    logic [11:0] e = '0;
    logic [5:0]  op = ins[31:26];
    logic [3:0]  f = 4'd0;
    logic        imm = 1'b0;
    kind_e       kind;
    int          len, p;
    case (op)
      6'b100000: begin kind = K_ALU; f = ins[3:0]; end
      6'b111000, 6'b110000: begin kind = K_ALU; imm = 1'b1; end
      6'b110010: begin kind = K_ALU; imm = 1'b1; f = 4'd2; end
      6'b110011: begin kind = K_ALU; imm = 1'b1; f = 4'd3; end
      6'b000011, 6'b001111: kind = K_LD;
      6'b000111, 6'b011111: kind = K_ST;
      6'b111111, 6'b000000, 6'b000001: kind = K_BR;
      default: kind = K_ILL;
    endcase
    case (kind)
      K_ALU:   len = 4;
      K_LD:    len = 4 + lat;
      K_ST:    len = 3 + lat;
      default: len = 3;
    endcase
    p = (k - 1) % len;
    case (kind)
      K_ALU: begin
        if (p == 2) begin e[B_ALUB] = imm; e[4:1] = f; end
        if (p == 3) begin e[B_PCEN] = 1'b1; e[B_RFWR] = 1'b1; e[B_DONE] = 1'b1; end
      end
      K_LD: begin
        if (p == len - 1) begin
          e[B_PCEN] = 1'b1; e[B_RFSW] = 1'b1; e[B_RFWR] = 1'b1; e[B_DONE] = 1'b1;
        end else if (p >= 2) e[B_ALUB] = 1'b1;
      end
      K_ST: begin
        if (p >= 2) begin e[B_ALUB] = 1'b1; e[B_RFSB] = 1'b1; end
        if (p == 3) e[B_MEMW] = 1'b1;
        if (p == len - 1) begin e[B_PCEN] = 1'b1; e[B_DONE] = 1'b1; end
      end
      K_BR: begin
        if (p == 2) begin
          e[B_PCEN] = 1'b1; e[B_RFSB] = 1'b1; e[4:1] = 4'd1; e[B_DONE] = 1'b1;
          e[B_PCSEL] = (op == 6'b111111) ? 1'b1 : (op == 6'b000000) ? z : ~z;
        end
      end
      default: begin
`ifndef ILLEGAL_TRAP_EN
        if (p == 2) begin e[B_PCEN] = 1'b1; e[B_DONE] = 1'b1; end
`endif
      end
    endcase
    return e;
  endfunction

  task automatic chk(string nm, int inst, int cyc, logic [11:0] got, logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d got %h exp %h", nm, inst, cyc, got, exp);
    end
  endtask

  // Leaves time at the negedge where cycle 1 (FETCH) begins.
  task automatic start(logic [31:0] ins, logic z);
    @(negedge clk);
    reset = 1'b1;
    instr = ins;
    zero  = z;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic [31:0] ins;
    logic        z;
    int          inst;
    int          cyc;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{"reset_fetch",  I_ADD,  1'b0, 2, 1, 12'h000});
    tbl.push_back('{"decode_quiet", I_SW,   1'b1, 1, 2, 12'h000});
    tbl.push_back('{"rtype_sub_ex", I_SUB,  1'b0, 0, 3, 12'h002});
    tbl.push_back('{"rtype_or_ex",  I_OR,   1'b0, 0, 3, 12'h006});
    tbl.push_back('{"rtype_add_wb", I_ADD,  1'b0, 0, 4, 12'h881});
    tbl.push_back('{"andi_ex",      I_ANDI, 1'b0, 1, 3, 12'h044});
    tbl.push_back('{"ori_ex",       I_ORI,  1'b0, 2, 3, 12'h046});
    tbl.push_back('{"li_ex",        I_LI,   1'b0, 0, 3, 12'h040});
    tbl.push_back('{"addi_wb",      I_ADDI, 1'b0, 1, 4, 12'h881});
    tbl.push_back('{"lw3_rd1",      I_LW,   1'b0, 2, 4, 12'h040});
    tbl.push_back('{"lw3_rd3",      I_LW,   1'b0, 2, 6, 12'h040});
    tbl.push_back('{"lw3_wb",       I_LW,   1'b0, 2, 7, 12'hA81});
    tbl.push_back('{"lb1_wb",       I_LB,   1'b0, 0, 5, 12'hA81});
    tbl.push_back('{"sw2_first",    I_SW,   1'b0, 1, 4, 12'h160});
    tbl.push_back('{"sw2_last",     I_SW,   1'b0, 1, 5, 12'h941});
    tbl.push_back('{"sb1_only",     I_SB,   1'b0, 0, 4, 12'h961});
    tbl.push_back('{"beq_z1",       I_BEQ,  1'b1, 0, 3, 12'hD03});
    tbl.push_back('{"beq_z0",       I_BEQ,  1'b0, 0, 3, 12'h903});
    tbl.push_back('{"bne_z1",       I_BNE,  1'b1, 1, 3, 12'h903});
    tbl.push_back('{"bne_z0",       I_BNE,  1'b0, 1, 3, 12'hD03});
    tbl.push_back('{"b_z0",         I_B,    1'b0, 2, 3, 12'hD03});
    tbl.push_back('{"illegal_c3",   I_ILL,  1'b0, 0, 3, ILL_C3});

    foreach (tbl[i]) begin
      start(tbl[i].ins, tbl[i].z);
      repeat (tbl[i].cyc - 1) @(negedge clk);
      #1;
      chk(tbl[i].nm, tbl[i].inst, tbl[i].cyc, obs[tbl[i].inst], tbl[i].exp);
    end

    // SW with MEM_LAT=2: one write strobe, PC_en only on the last cycle, no RF write.
    begin
      int mw = 0;
      int rw = 0;
      start(I_SW, 1'b0);
      for (int k = 1; k <= 5; k++) begin
        #1;
        mw += int'(obs[1][B_MEMW]);
        rw += int'(obs[1][B_RFWR]);
        chk("sw2_pc_en", 1, k, {11'd0, obs[1][B_PCEN]}, {11'd0, k == 5});
        @(negedge clk);
      end
      chk("sw2_memwr_count", 1, 5, 12'(mw), 12'd1);
      chk("sw2_rfwr_count", 1, 5, 12'(rw), 12'd0);
    end

`ifdef ILLEGAL_TRAP_EN
    begin
      int pcs = 0;
      start(I_ILL, 1'b0);
      for (int k = 1; k <= 20; k++) begin
        zero = 1'(k);
        #1;
        for (int i = 0; i < 3; i++) pcs += int'(obs[i][B_PCEN]);
        @(negedge clk);
      end
      chk("trap_no_pc_en", 0, 20, 12'(pcs), 12'd0);
    end
`else
    start(I_ILL, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("illegal_back_to_fetch", 0, 4, obs[0], 12'h000);
`endif

    // Reset during the second MEM_WR cycle of a MEM_LAT=3 store.
    begin
      int mw = 0;
      start(I_SW, 1'b0);
      repeat (4) @(negedge clk);
      #1;
      chk("mid_sw_pre", 2, 5, obs[2], 12'h140);
      #2;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) chk("reset_async_zero", i, 5, obs[i], 12'h000);
      instr = I_ADD;
      repeat (2) begin
        @(negedge clk);
        #1;
        mw += int'(obs[2][B_MEMW]);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        #1;
        mw += int'(obs[2][B_MEMW]);
        chk("post_reset_seq", 2, k, obs[2], model(I_ADD, zero, 3, k));
        @(negedge clk);
      end
      chk("post_reset_memwr", 2, 4, 12'(mw), 12'd0);
    end

    // Randomized instructions against the phase model on all three latencies.
    begin
      logic [31:0] r;
      logic [31:0] ins;
      logic [5:0]  ops [14];
      ops = '{6'b100000, 6'b111000, 6'b110000, 6'b110010, 6'b110011, 6'b111111, 6'b000000,
              6'b000001, 6'b000011, 6'b001111, 6'b000111, 6'b011111, 6'b101010, 6'b010101};
      for (int n = 0; n < 80; n++) begin
        r   = $urandom;
        ins = {ops[$urandom_range(0, 13)], r[25:0]};
        if (n % 10 == 9) ins[31:26] = 6'($urandom);
        start(ins, 1'b0);
        for (int k = 1; k <= 14; k++) begin
          zero = 1'($urandom_range(0, 1));
          #1;
          for (int i = 0; i < 3; i++) chk("random", i, k, obs[i], model(ins, zero, i + 1, k));
          @(negedge clk);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
